// File: rtl/aes_pkg.sv
// Shared AES ShiftRows helpers: row offsets, FIPS-197 byte positions,
// column-count legality and the skid buffer state encoding.
package aes_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Rijndael row offsets: 0,1,2,3 for 4/6 columns, 0,1,3,4 for 8 columns.
   function automatic int shift_off(input int nb, input int r);
      if (nb == 8 && r >= 2)
         return r + 1;
      return r;
   endfunction

   // Bit index of the LSB of byte (row r, column c); column 0 sits at the MSB end.
   function automatic int byte_lsb(input int nb, input int r, input int c);
      return 32*nb - 8 - 32*c - 8*r;
   endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB columns.
// Also instantiated by the key-expansion and decrypt paths.
import aes_pkg::*;

module aes_shift_rows_perm #(
   parameter int NB = 4,
   parameter int W  = 32*NB
) (
   input  logic         inv,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   if (!nb_legal(NB) || W != 32*NB) begin : g_bad_nb
      $error("aes_shift_rows_perm: NB must be 4, 6 or 8 and W must equal 32*NB");
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         // Forward pulls from c+Cr; inverse is the mirror, pulling from c-Cr.
         localparam int SRC_FWD = (c + shift_off(NB, r)) % NB;
         localparam int SRC_INV = (c + NB - shift_off(NB, r)) % NB;
         assign dout[byte_lsb(NB, r, c) +: 8] = inv ? din[byte_lsb(NB, r, SRC_INV) +: 8]
                                                    : din[byte_lsb(NB, r, SRC_FWD) +: 8];
      end
   end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows stage with valid/ready flow control via a 2-entry
// skid buffer, per-block direction select and a wrapping output block counter.
//
//   state     | meaning
//   BUF_EMPTY | nothing held; out_valid=0, in_ready=1
//   BUF_ONE   | output register holds a block; out_valid=1, in_ready=1
//   BUF_FULL  | output and skid entry both held; out_valid=1, in_ready=0
import aes_pkg::*;

module aes_shift_rows_pipe #(
   parameter  int NB    = 4,
   parameter  int CNT_W = 16,
   localparam int W     = 32*NB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_inv,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_inv,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] blk_cnt
);

   buf_state_e   state;
   logic [W-1:0] perm_data;
   logic [W-1:0] skid_data;
   logic         skid_inv;
   logic         in_fire;
   logic         out_fire;

   aes_shift_rows_perm #(
      .NB (NB),
      .W  (W)
   ) u_perm (
      .inv  (in_inv),
      .din  (in_data),
      .dout (perm_data)
   );

   // in_ready is decoded from registered state only; rst gates it low while held.
   assign in_ready  = (state != BUF_FULL) && !rst;
   assign out_valid = (state != BUF_EMPTY);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BUF_EMPTY;
         out_data  <= '0;
         out_inv   <= 1'b0;
         skid_data <= '0;
         skid_inv  <= 1'b0;
         blk_cnt   <= '0;
      end else if (flush) begin
         state     <= BUF_EMPTY;
         out_data  <= '0;
         out_inv   <= 1'b0;
         skid_data <= '0;
         skid_inv  <= 1'b0;
      end else begin
         if (out_fire)
            blk_cnt <= blk_cnt + 1'b1;
         case (state)
            BUF_EMPTY: begin
               if (in_fire) begin
                  out_data <= perm_data;
                  out_inv  <= in_inv;
                  state    <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               case ({in_fire, out_fire})
                  2'b10: begin
                     skid_data <= perm_data;
                     skid_inv  <= in_inv;
                     state     <= BUF_FULL;
                  end
                  2'b01: state <= BUF_EMPTY;
                  2'b11: begin
                     out_data <= perm_data;
                     out_inv  <= in_inv;
                  end
                  default: ;
               endcase
            end
            BUF_FULL: begin
               if (out_fire) begin
                  out_data <= skid_data;
                  out_inv  <= skid_inv;
                  state    <= BUF_ONE;
               end
            end
            default: state <= BUF_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: NB=4 instance with a 16-bit
// counter and NB=8 instance with a 4-bit counter, directed FIPS-197 vectors.
module tb_aes_shift_rows_pipe;

   localparam logic [127:0] VA     = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] VB     = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] VA_INV = 128'hd4415df1e02752e5b8bf11301eb498ae;
   localparam logic [127:0] VB_FWD = 128'hd4b411e5e0419830b8275dae1ebf52f1;
   localparam logic [255:0] S8 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] F8 =
      256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic         flush4 = 1'b0, in_valid4 = 1'b0, in_inv4 = 1'b0, out_ready4 = 1'b0;
   logic [127:0] in_data4 = '0;
   logic         in_ready4, out_valid4, out_inv4;
   logic [127:0] out_data4;
   logic [15:0]  blk_cnt4;

   logic         flush8 = 1'b0, in_valid8 = 1'b0, in_inv8 = 1'b0, out_ready8 = 1'b1;
   logic [255:0] in_data8 = '0;
   logic         in_ready8, out_valid8, out_inv8;
   logic [255:0] out_data8;
   logic [3:0]   blk_cnt8;

   int n_checks = 0;
   int n_fail   = 0;

   logic [128:0] exp4_q[$];
   logic [256:0] exp8_q[$];

   always #5 clk = ~clk;

   aes_shift_rows_pipe #(.NB(4), .CNT_W(16)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_inv(out_inv4),
      .out_data(out_data4), .blk_cnt(blk_cnt4)
   );

   aes_shift_rows_pipe #(.NB(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .flush(flush8),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_inv(out_inv8),
      .out_data(out_data8), .blk_cnt(blk_cnt8)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s actual=timeout/unexpected required=event", name);
   endtask

   task automatic send4(input logic [127:0] d, input logic inv, input logic [127:0] e);
      int n;
      in_valid4 = 1'b1; in_data4 = d; in_inv4 = inv; n = 0;
      @(negedge clk);
      while (!in_ready4 && n < 40) begin @(negedge clk); n++; end
      if (!in_ready4) fail("send4_timeout");
      else exp4_q.push_back({inv, e});
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   task automatic send8(input logic [255:0] d, input logic inv, input logic [255:0] e);
      int n;
      in_valid8 = 1'b1; in_data8 = d; in_inv8 = inv; n = 0;
      @(negedge clk);
      while (!in_ready8 && n < 40) begin @(negedge clk); n++; end
      if (!in_ready8) fail("send8_timeout");
      else exp8_q.push_back({inv, e});
      @(posedge clk); #1;
      in_valid8 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 60) begin
         @(negedge clk); n++;
      end
      if (exp4_q.size() != 0 || exp8_q.size() != 0) fail(name);
      @(posedge clk); #1;
   endtask

   // NB=4 monitor: data/inv order, blk_cnt model, output stability while stalled.
   initial begin
      logic [15:0]  cnt4;
      logic         hold4;
      logic [128:0] hold_val4;
      logic [128:0] e;
      cnt4 = '0; hold4 = 1'b0; hold_val4 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt4 = '0; hold4 = 1'b0;
         end else begin
            if (hold4 && out_valid4)
               check("hold4", {out_inv4, out_data4}, hold_val4);
            if (out_valid4 && out_ready4 && !flush4) begin
               if (exp4_q.size() == 0) fail("unexpected_out4");
               else begin
                  e = exp4_q.pop_front();
                  check("data4", out_data4, e[127:0]);
                  check("inv4", out_inv4, e[128]);
               end
               check("blk_cnt4", blk_cnt4, cnt4);
               cnt4 = cnt4 + 1'b1;
            end
            hold4 = out_valid4 && !out_ready4 && !flush4;
            hold_val4 = {out_inv4, out_data4};
         end
      end
   end

   initial begin
      logic [3:0]   cnt8;
      logic [256:0] e;
      cnt8 = '0;
      forever begin
         @(negedge clk);
         if (rst) cnt8 = '0;
         else if (out_valid8 && out_ready8 && !flush8) begin
            if (exp8_q.size() == 0) fail("unexpected_out8");
            else begin
               e = exp8_q.pop_front();
               check("data8", out_data8, e[255:0]);
               check("inv8", out_inv8, e[256]);
            end
            check("blk_cnt8", blk_cnt8, cnt8);
            cnt8 = cnt8 + 1'b1;
         end
      end
   end

   initial begin
      logic [15:0] saved_cnt;

      // Reset
      repeat (2) @(negedge clk);
      check("rst_in_ready4", in_ready4, 1'b0);
      check("rst_in_ready8", in_ready8, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid4, 1'b0);
      check("reset_out_data", out_data4, '0);
      check("reset_out_inv", out_inv4, 1'b0);
      check("reset_blk_cnt", blk_cnt4, '0);
      check("reset_in_ready", in_ready4, 1'b1);
      @(posedge clk); #1;

      // NB=4 forward / inverse FIPS-197 vectors, one-cycle latency
      out_ready4 = 1'b1;
      send4(VA, 1'b0, VB);
      @(negedge clk);
      check("latency_valid", out_valid4, 1'b1);
      check("latency_data", out_data4, VB);
      @(posedge clk); #1;
      send4(VB, 1'b1, VA);
      drain("drain_basic");
      check("blk_cnt_after2", blk_cnt4, 16'd2);

      // Back-pressure with alternating directions
      out_ready4 = 1'b0;
      send4(VA, 1'b0, VB);
      send4(VB, 1'b1, VA);
      in_valid4 = 1'b1; in_data4 = VA; in_inv4 = 1'b1;
      @(negedge clk);
      check("bp_in_ready_a", in_ready4, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_in_ready_b", in_ready4, 1'b0);
      check("bp_out_data", out_data4, VB);
      @(posedge clk); #1;
      out_ready4 = 1'b1;
      send4(VA, 1'b1, VA_INV);
      send4(VB, 1'b0, VB_FWD);
      drain("drain_bp");
      check("blk_cnt_after_bp", blk_cnt4, 16'd6);

      // NB=8 round trip, then 17 blocks total on the 4-bit counter
      send8(S8, 1'b0, F8);
      send8(F8, 1'b1, S8);
      for (int i = 0; i < 15; i++) begin
         if (i % 2 == 0) send8(S8, 1'b0, F8);
         else            send8(F8, 1'b1, S8);
      end
      drain("drain_nb8");
      check("blk_cnt8_wrap", blk_cnt8, 4'd1);

      // Flush from FULL, with an in_valid and an out_fire in the flush cycle
      out_ready4 = 1'b0;
      send4(VA, 1'b0, VB);
      send4(VB, 1'b1, VA);
      @(negedge clk);
      check("full_in_ready", in_ready4, 1'b0);
      saved_cnt = blk_cnt4;
      @(posedge clk); #1;
      flush4 = 1'b1; in_valid4 = 1'b1; in_data4 = VA; in_inv4 = 1'b0; out_ready4 = 1'b1;
      exp4_q.delete();
      @(posedge clk); #1;
      flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid4, 1'b0);
      check("flush_in_ready", in_ready4, 1'b1);
      check("flush_out_data", out_data4, '0);
      check("flush_blk_cnt", blk_cnt4, saved_cnt);
      @(posedge clk); #1;

      // Reset mid-stream with both entries occupied
      send4(VA, 1'b1, VA_INV);
      send4(VB, 1'b0, VB_FWD);
      rst = 1'b1; in_valid4 = 1'b1; in_data4 = VA; in_inv4 = 1'b0;
      exp4_q.delete();
      exp8_q.delete();
      @(negedge clk);
      check("midrst_in_ready_pre", in_ready4, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_out_valid", out_valid4, 1'b0);
      check("midrst_out_data", out_data4, '0);
      check("midrst_out_inv", out_inv4, 1'b0);
      check("midrst_blk_cnt", blk_cnt4, '0);
      check("midrst_in_ready", in_ready4, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid4 = 1'b0;
      @(negedge clk);
      check("postrst_in_ready", in_ready4, 1'b1);
      @(posedge clk); #1;

      // Recovery after reset
      out_ready4 = 1'b1;
      send4(VA, 1'b1, VA_INV);
      drain("drain_final");
      check("blk_cnt_final", blk_cnt4, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
